// File: rtl/ctrl_pipe_hazard.sv
// ID->EX->MEM->WB control pipeline with load-use stall, jr flush and EX-stage forwarding selects.
// Latency 1/2/3 cycles to ex_/mem_/wb_; stall holds upstream one cycle, later stages never stall.
module ctrl_pipe_hazard #(
  parameter int RA_W   = 5,
  parameter int ALUC_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ALUC_W-1:0] id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_pc_src,
  input  logic              id_mem_write,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  output logic              ex_valid,
  output logic [ALUC_W-1:0] ex_alu_ctrl,
  output logic              ex_alu_src,
  output logic              ex_pc_src,
  output logic              ex_mem_to_reg,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_dst,
  output logic              mem_valid,
  output logic              mem_mem_write,
  output logic              mem_mem_read,
  output logic              mem_mem_to_reg,
  output logic              mem_reg_write,
  output logic [RA_W-1:0]   mem_dst,
  output logic              wb_valid,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic [RA_W-1:0]   wb_dst,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  typedef struct packed {
    logic              valid;
    logic [ALUC_W-1:0] aluCtrl;
    logic              aluSrc;
    logic              pcSrc;
    logic              memWrite;
    logic              memRead;
    logic              memToReg;
    logic              regWrite;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   dst;
  } exStage_t;

  typedef struct packed {
    logic            valid;
    logic            memWrite;
    logic            memRead;
    logic            memToReg;
    logic            regWrite;
    logic [RA_W-1:0] dst;
  } memStage_t;

  typedef struct packed {
    logic            valid;
    logic            memToReg;
    logic            regWrite;
    logic [RA_W-1:0] dst;
  } wbStage_t;

  exStage_t  exQ,  exD;
  memStage_t memQ, memD;
  wbStage_t  wbQ,  wbD;
  logic      idUsesRt;
  logic      loadUse;

  function automatic logic [1:0] fwdSel(input memStage_t m, input wbStage_t w,
                                        input logic [RA_W-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    // A load in MEM has no data yet; only ALU results forward from EX/MEM.
    if (m.valid && m.regWrite && !m.memToReg && (m.dst != '0) && (m.dst == src))
      sel = 2'b10;
    else if (w.valid && w.regWrite && (w.dst != '0) && (w.dst == src))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    idUsesRt = ~id_alu_src | id_mem_write;
    loadUse  = id_valid & exQ.valid & exQ.memToReg & (exQ.dst != '0) &
               ((exQ.dst == id_rs) | (idUsesRt & (exQ.dst == id_rt)));
    flush    = exQ.valid & exQ.pcSrc;
    stall    = loadUse & ~flush;
    fwd_a    = fwdSel(memQ, wbQ, exQ.rs);
    fwd_b    = fwdSel(memQ, wbQ, exQ.rt);
  end

  always_comb begin
    exD = '0;
    if (id_valid && !stall && !flush) begin
      exD.valid    = 1'b1;
      exD.aluCtrl  = id_alu_ctrl;
      exD.aluSrc   = id_alu_src;
      exD.pcSrc    = id_pc_src;
      exD.memWrite = id_mem_write;
      exD.memRead  = id_mem_read;
      exD.memToReg = id_mem_to_reg;
      exD.regWrite = id_reg_write;
      exD.rs       = id_rs;
      exD.rt       = id_rt;
      exD.dst      = id_reg_dst ? id_rd : id_rt;
    end
  end

  always_comb begin
    memD.valid    = exQ.valid;
    memD.memWrite = exQ.memWrite;
    memD.memRead  = exQ.memRead;
    memD.memToReg = exQ.memToReg;
    memD.regWrite = exQ.regWrite;
    memD.dst      = exQ.dst;
    wbD.valid     = memQ.valid;
    wbD.memToReg  = memQ.memToReg;
    wbD.regWrite  = memQ.regWrite;
    wbD.dst       = memQ.dst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exQ  <= '0;
      memQ <= '0;
      wbQ  <= '0;
    end else begin
      exQ  <= exD;
      memQ <= memD;
      wbQ  <= wbD;
    end
  end

  assign ex_valid       = exQ.valid;
  assign ex_alu_ctrl    = exQ.aluCtrl;
  assign ex_alu_src     = exQ.aluSrc;
  assign ex_pc_src      = exQ.pcSrc;
  assign ex_mem_to_reg  = exQ.memToReg;
  assign ex_rs          = exQ.rs;
  assign ex_rt          = exQ.rt;
  assign ex_dst         = exQ.dst;
  assign mem_valid      = memQ.valid;
  assign mem_mem_write  = memQ.memWrite;
  assign mem_mem_read   = memQ.memRead;
  assign mem_mem_to_reg = memQ.memToReg;
  assign mem_reg_write  = memQ.regWrite;
  assign mem_dst        = memQ.dst;
  assign wb_valid       = wbQ.valid;
  assign wb_mem_to_reg  = wbQ.memToReg;
  assign wb_reg_write   = wbQ.regWrite;
  assign wb_dst         = wbQ.dst;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: instruction-level pipeline model checked every cycle plus literal pins.
module tb_ctrl_pipe_hazard;

  typedef struct packed {
    logic       v;
    logic [1:0] aluc;
    logic       alus;
    logic       rdst;
    logic       pcs;
    logic       mw;
    logic       mr;
    logic       m2r;
    logic       rw;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] dst;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ins_t curId = '0;
  bit   chkEn = 1'b0;
  int   nTests = 0;
  int   nFail = 0;

  // Model: whole instructions sitting in EX, MEM and WB
  ins_t mEx = '0, mMem = '0, mWb = '0;

  logic       ex_valid, ex_alu_src, ex_pc_src, ex_mem_to_reg;
  logic [1:0] ex_alu_ctrl;
  logic [4:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic       mem_valid, mem_mem_write, mem_mem_read, mem_mem_to_reg, mem_reg_write;
  logic       wb_valid, wb_mem_to_reg, wb_reg_write;
  logic       stall, flush;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  ctrl_pipe_hazard #(.RA_W(5), .ALUC_W(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(curId.v), .id_alu_ctrl(curId.aluc), .id_alu_src(curId.alus),
    .id_reg_dst(curId.rdst), .id_pc_src(curId.pcs), .id_mem_write(curId.mw),
    .id_mem_read(curId.mr), .id_mem_to_reg(curId.m2r), .id_reg_write(curId.rw),
    .id_rs(curId.rs), .id_rt(curId.rt), .id_rd(curId.rd),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src),
    .ex_pc_src(ex_pc_src), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .mem_valid(mem_valid), .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
    .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_dst(wb_dst), .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic [1:0] aluc, input logic alus, input logic rdst,
                              input logic pcs, input logic mw, input logic mr, input logic m2r,
                              input logic rw, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.aluc = aluc; i.alus = alus; i.rdst = rdst; i.pcs = pcs;
    i.mw = mw; i.mr = mr; i.m2r = m2r; i.rw = rw; i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t lw(input logic [4:0] rs, input logic [4:0] rt);
    return mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, rs, rt, 5'd0);
  endfunction
  function automatic ins_t sw(input logic [4:0] rs, input logic [4:0] rt);
    return mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rs, rt, 5'd0);
  endfunction
  function automatic ins_t ori(input logic [4:0] rs, input logic [4:0] rt);
    return mk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rs, rt, 5'd0);
  endfunction
  function automatic ins_t mul(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return mk(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rs, rt, rd);
  endfunction
  function automatic ins_t jr(input logic [4:0] rs);
    return mk(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rs, 5'd0, 5'd0);
  endfunction

  function automatic logic expFlush(input ins_t ex);
    return ex.v && ex.pcs;
  endfunction

  function automatic logic expStall(input ins_t ex, input ins_t id);
    logic reads;
    reads = (ex.dst == id.rs) || ((!id.alus || id.mw) && (ex.dst == id.rt));
    return id.v && ex.v && ex.m2r && (ex.dst != 0) && reads && !expFlush(ex);
  endfunction

  function automatic logic [1:0] expFwd(input ins_t m, input ins_t w, input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (m.v && m.rw && !m.m2r && m.dst == r) return 2'b10;
    if (w.v && w.rw && w.dst == r) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    logic f, s;
    f = expFlush(mEx);
    s = expStall(mEx, curId);
    if (rst) begin
      mEx = '0; mMem = '0; mWb = '0;
    end else begin
      mWb  = mMem;
      mMem = mEx;
      if (f || s || !curId.v) mEx = '0;
      else begin
        mEx = curId;
        mEx.dst = curId.rdst ? curId.rd : curId.rt;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("ex_valid", ex_valid, mEx.v);
      chk("ex_alu_ctrl", ex_alu_ctrl, mEx.aluc);
      chk("ex_alu_src", ex_alu_src, mEx.alus);
      chk("ex_pc_src", ex_pc_src, mEx.pcs);
      chk("ex_mem_to_reg", ex_mem_to_reg, mEx.m2r);
      chk("ex_rs", ex_rs, mEx.rs);
      chk("ex_rt", ex_rt, mEx.rt);
      chk("ex_dst", ex_dst, mEx.dst);
      chk("mem_valid", mem_valid, mMem.v);
      chk("mem_mem_write", mem_mem_write, mMem.mw);
      chk("mem_mem_read", mem_mem_read, mMem.mr);
      chk("mem_mem_to_reg", mem_mem_to_reg, mMem.m2r);
      chk("mem_reg_write", mem_reg_write, mMem.rw);
      chk("mem_dst", mem_dst, mMem.dst);
      chk("wb_valid", wb_valid, mWb.v);
      chk("wb_mem_to_reg", wb_mem_to_reg, mWb.m2r);
      chk("wb_reg_write", wb_reg_write, mWb.rw);
      chk("wb_dst", wb_dst, mWb.dst);
      chk("stall", stall, expStall(mEx, curId));
      chk("flush", flush, expFlush(mEx));
      chk("fwd_a", fwd_a, expFwd(mMem, mWb, mEx.rs));
      chk("fwd_b", fwd_b, expFwd(mMem, mWb, mEx.rt));
    end
  end

  // Present one ID slot for one cycle; returns at the following negedge.
  task automatic drive(input ins_t i, input logic r);
    @(posedge clk);
    #1;
    rst = r;
    curId = i;
    @(negedge clk);
  endtask

  function automatic ins_t rndIns();
    logic [31:0] x;
    ins_t i;
    x = $urandom;
    i = ins_t'(x[29:0]);
    i.dst = '0;
    return i;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, nTests=%0d", nTests);
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    chkEn = 1'b1;

    // reset with random ID inputs
    for (int k = 0; k < 2; k++) begin
      drive(rndIns(), 1'b1);
      chk("rst ex_valid", ex_valid, 0);
      chk("rst mem_valid", mem_valid, 0);
      chk("rst wb_valid", wb_valid, 0);
      chk("rst wb_reg_write", wb_reg_write, 0);
      chk("rst ex_dst", ex_dst, 0);
      chk("rst stall", stall, 0);
      chk("rst fwd_a", fwd_a, 0);
    end
    drive('0, 1'b0);
    chk("post-rst stall", stall, 0);
    chk("post-rst flush", flush, 0);
    chk("post-rst fwd_b", fwd_b, 0);

    // load-use: lw r8 then mul r8,r9
    drive(lw(5'd1, 5'd8), 1'b0);
    drive(mul(5'd8, 5'd9, 5'd10), 1'b0);
    chk("lu stall", stall, 1);
    chk("lu flush", flush, 0);
    drive(mul(5'd8, 5'd9, 5'd10), 1'b0);
    chk("lu bubble ex_valid", ex_valid, 0);
    chk("lu one-cycle stall", stall, 0);
    drive('0, 1'b0);
    chk("lu mul ex_valid", ex_valid, 1);
    chk("lu ex_dst", ex_dst, 10);
    chk("lu fwd_a", fwd_a, 2'b01);
    chk("lu fwd_b", fwd_b, 2'b00);

    // EX/MEM forwarding
    drive(ori(5'd0, 5'd5), 1'b0);
    drive(mul(5'd5, 5'd5, 5'd6), 1'b0);
    drive('0, 1'b0);
    chk("fw exmem a", fwd_a, 2'b10);
    chk("fw exmem b", fwd_b, 2'b10);

    // MEM/WB forwarding across one bubble
    drive(ori(5'd0, 5'd5), 1'b0);
    drive('0, 1'b0);
    drive(mul(5'd5, 5'd5, 5'd6), 1'b0);
    drive('0, 1'b0);
    chk("fw memwb a", fwd_a, 2'b01);
    chk("fw memwb b", fwd_b, 2'b01);

    // both stages match: EX/MEM wins
    drive(ori(5'd0, 5'd5), 1'b0);
    drive(ori(5'd0, 5'd5), 1'b0);
    drive(mul(5'd5, 5'd7, 5'd6), 1'b0);
    drive('0, 1'b0);
    chk("fw prio a", fwd_a, 2'b10);
    chk("fw prio b", fwd_b, 2'b00);

    // load in MEM is not forwarded; ori does not read rt
    drive(lw(5'd1, 5'd3), 1'b0);
    drive(ori(5'd1, 5'd3), 1'b0);
    chk("ori no stall", stall, 0);
    drive('0, 1'b0);
    chk("no fwd from load", fwd_b, 2'b00);

    // register zero
    drive(ori(5'd1, 5'd0), 1'b0);
    drive(lw(5'd1, 5'd0), 1'b0);
    drive(mul(5'd0, 5'd0, 5'd11), 1'b0);
    chk("r0 stall", stall, 0);
    drive('0, 1'b0);
    chk("r0 fwd_a", fwd_a, 2'b00);
    chk("r0 fwd_b", fwd_b, 2'b00);

    // jr flush
    drive(jr(5'd31), 1'b0);
    drive(ori(5'd0, 5'd4), 1'b0);
    chk("jr flush", flush, 1);
    chk("jr stall", stall, 0);
    drive('0, 1'b0);
    chk("jr ex killed", ex_valid, 0);
    chk("jr mem_valid", mem_valid, 1);
    chk("jr mem_reg_write", mem_reg_write, 0);
    chk("jr mem_mem_write", mem_mem_write, 0);
    chk("jr mem_mem_read", mem_mem_read, 0);

    // flush and load-use together: flush wins
    drive(mk(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd12, 5'd0), 1'b0);
    drive(mul(5'd12, 5'd1, 5'd2), 1'b0);
    chk("both flush", flush, 1);
    chk("both stall", stall, 0);
    drive('0, 1'b0);
    chk("both ex killed", ex_valid, 0);

    // store reads rt even though alu_src=1
    drive(lw(5'd1, 5'd13), 1'b0);
    drive(sw(5'd2, 5'd13), 1'b0);
    chk("sw stall", stall, 1);
    drive(sw(5'd2, 5'd13), 1'b0);
    chk("sw bubble", ex_valid, 0);
    drive('0, 1'b0);
    chk("sw ex_valid", ex_valid, 1);
    chk("sw fwd_b", fwd_b, 2'b01);

    // reset during a stall cycle
    drive(lw(5'd1, 5'd9), 1'b0);
    drive(mul(5'd9, 5'd0, 5'd2), 1'b1);
    chk("rs stall before", stall, 1);
    drive(mul(5'd9, 5'd0, 5'd2), 1'b0);
    chk("rs ex_valid", ex_valid, 0);
    chk("rs mem_valid", mem_valid, 0);
    chk("rs wb_valid", wb_valid, 0);
    chk("rs stall", stall, 0);

    for (int k = 0; k < 4; k++) drive('0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
Consumer end of the main-control decoder interface. Carries decoded control bits and register specifiers from ID through the ID/EX, EX/MEM and MEM/WB stages. Detects load-use hazards (stall plus bubble), flushes on jr resolved in EX, and generates EX-stage forwarding selects. Sits between the decoder and the datapath pipeline registers.

Parameters:
RA_W, 5, register-address width
ALUC_W, 2, ALUControl width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_alu_ctrl  in  ALUC_W  decoder ALUControl
id_alu_src  in  1  decoder ALUSrc
id_reg_dst  in  1  decoder RegDst (1 = rd, 0 = rt)
id_pc_src  in  1  decoder PCSrc (jr)
id_mem_write  in  1  decoder MemWrite
id_mem_read  in  1  decoder MemRead
id_mem_to_reg  in  1  decoder MemtoReg (load)
id_reg_write  in  1  decoder RegWrite
id_rs, id_rt, id_rd  in  RA_W  instruction fields
ex_valid, ex_alu_ctrl, ex_alu_src, ex_pc_src, ex_mem_to_reg  out  1/ALUC_W/1/1/1  ID/EX control
ex_rs, ex_rt, ex_dst  out  RA_W  ID/EX registers; ex_dst = id_reg_dst ? id_rd : id_rt at capture
mem_valid, mem_mem_write, mem_mem_read, mem_mem_to_reg, mem_reg_write  out  1  EX/MEM control
mem_dst  out  RA_W  EX/MEM destination
wb_valid, wb_mem_to_reg, wb_reg_write  out  1  MEM/WB control
wb_dst  out  RA_W  MEM/WB destination
stall  out  1  combinational; hold PC and IF/ID this cycle
flush  out  1  combinational; kill IF/ID contents and redirect PC
fwd_a, fwd_b  out  2  combinational EX operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB

Behaviour:
- Reset (rst=1 at an edge): every registered output is 0, including all valid, control and dst fields. Reset wins over every other condition, including mid-stall or mid-flush. The cycle after reset, stall=0, flush=0 and fwd=00.
- Bubble: a stage entry with valid=0 and all control bits 0. Register fields are don't-care but are driven to 0.
- Advance: each edge does ID->EX, EX->MEM and MEM->WB. EX/MEM and MEM/WB always advance; they never stall.
- id_uses_rt = ~id_alu_src | id_mem_write.
- Load-use: load_use = id_valid & ex_valid & ex_mem_to_reg & (ex_dst != 0) & (ex_dst == id_rs | (id_uses_rt & ex_dst == id_rt)).
  - stall = load_use & ~flush.
  - When stall=1, ID/EX loads a bubble. The upstream holds the ID instruction, and it re-enters next cycle. The stall lasts exactly 1 cycle.
- Flush: flush = ex_valid & ex_pc_src.
  - ID/EX loads a bubble regardless of id_valid or load_use.
  - Flush has priority over stall.
  - There is no jr-after-jr chaining; the ID slot is simply killed.
- ID capture when neither stall nor flush: the ex_* fields take the id_* values, and ex_valid = id_valid. If id_valid=0, the stage captures a bubble.
- Forwarding, fwd_a (compare ex_rs):
  - 10 if mem_valid & mem_reg_write & ~mem_mem_to_reg & mem_dst != 0 & mem_dst == ex_rs.
  - Otherwise 01 if wb_valid & wb_reg_write & wb_dst != 0 & wb_dst == ex_rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB.
- Forwarding, fwd_b: same rules comparing ex_rt.
- Register 0 never causes a stall or a forward.
- Latency: a control bit presented in ID appears in ex_* 1 cycle later, mem_* 2 cycles later and wb_* 3 cycles later, absent stall or flush.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random id_* inputs -> all outputs 0; stall=0, flush=0, fwd_a=fwd_b=00.
- Load-use: lw r8 (mem_to_reg=1, reg_write=1, alu_src=1, rd/rt=8), then mul (alu_src=0, rs=8, rt=9) -> stall=1 for exactly 1 cycle and ex_valid=0 the next cycle. mul enters EX the cycle after, with fwd_a=01.
- Forwarding: ori r5 (rt=5), then mul (rs=5, rt=5) -> in mul's EX cycle fwd_a=10 and fwd_b=10. One intervening bubble -> fwd_a=fwd_b=01. Back-to-back ori r5, ori r5, then mul rs=5 -> fwd_a=10.
- Register zero: lw r0, then mul (rs=0) -> stall=0, fwd_a=00.
- jr flush: jr (pc_src=1) in EX with ori in ID -> flush=1. Next cycle ex_valid=0 and mem_valid=1 with all mem_* control 0 for jr. Simultaneous load_use and flush -> stall=0, flush=1.
- Reset mid-stall: assert rst on the stall cycle -> next cycle all stage valids=0 and stall=0.
